// File: rtl/pipelined_subtractor_if.sv
// Handshake bundle for the pipelined add/subtract unit: operand side
// (in_valid/in_ready) and result side (out_valid/out_ready).
interface pipelined_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             co;
  logic             ov;

  // Master supplies operands and consumes results.
  modport master (
    output in_valid, a, b, ci, mode, out_ready,
    input  in_ready, out_valid, d, co, ov
  );

  modport slave (
    input  in_valid, a, b, ci, mode, out_ready,
    output in_ready, out_valid, d, co, ov
  );
endinterface

// File: rtl/pipelined_subtractor.sv
// Add/subtract unit whose carry chain is split into STAGES registered chunks
// of CW bits; the last stage register doubles as the output register.
module pipelined_subtractor #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_subtractor_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  logic             advance;

  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] r_in [STAGES];
  logic [WIDTH-1:0] r_nx [STAGES];
  logic             c_in [STAGES];
  logic             c_nx [STAGES];
  logic             m_in [STAGES];
  logic             v_in [STAGES];

  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] r_q  [STAGES];
  logic             c_q  [STAGES];
  logic             m_q  [STAGES];
  logic             v_q  [STAGES];

  logic             co_nx;
  logic             ov_nx;
  logic             co_q;
  logic             ov_q;

  assign advance      = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction runs as a + ~b + ~ci, so every stage is a plain adder chunk
  // and the internal carry is the inverse of the borrow.
  assign a_in[0] = bus.a;
  assign b_in[0] = bus.mode ? bus.b : ~bus.b;
  assign c_in[0] = bus.mode ? bus.ci : ~bus.ci;
  assign m_in[0] = bus.mode;
  assign v_in[0] = bus.in_valid;
  assign r_in[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW:0]      sum;
    logic [WIDTH-1:0] res;

    if (k > 0) begin : g_link
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign r_in[k] = r_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign m_in[k] = m_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    assign sum = {1'b0, a_in[k][k*CW +: CW]}
               + {1'b0, b_in[k][k*CW +: CW]}
               + {{CW{1'b0}}, c_in[k]};

    always_comb begin
      res                = r_in[k];
      res[k*CW +: CW]    = sum[CW-1:0];
    end

    assign r_nx[k] = res;
    assign c_nx[k] = sum[CW];
  end

  // Overflow: operands (after b inversion) agree in sign but the result does not.
  assign co_nx = m_in[STAGES-1] ? c_nx[STAGES-1] : ~c_nx[STAGES-1];
  assign ov_nx = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
                 (r_nx[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
      end
      co_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        r_q[k] <= r_nx[k];
        c_q[k] <= c_nx[k];
        m_q[k] <= m_in[k];
      end
      co_q <= co_nx;
      ov_q <= ov_nx;
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.d         = r_q[STAGES-1];
  assign bus.co        = co_q;
  assign bus.ov        = ov_q;
endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed plus short random bench for pipelined_subtractor; a negedge monitor
// compares every output transfer against a scoreboard filled on input transfer.
module tb_pipelined_subtractor;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       co;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_subtractor_if #(.WIDTH(WIDTH)) bus ();

  pipelined_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   accepted = 0;

  logic [7:0] va [4] = '{8'h10, 8'hA5, 8'h3C, 8'h00};
  logic [7:0] vb [4] = '{8'h01, 8'h5A, 8'hC4, 8'h01};
  logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic       vm [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic done on wide integers, independent of the chunked adder.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic mode);
    exp_t e;
    int   ur;
    int   sr;
    if (mode) begin
      ur   = int'(a) + int'(b) + int'(ci);
      sr   = int'($signed(a)) + int'($signed(b)) + int'(ci);
      e.co = (ur > 255);
    end else begin
      ur   = int'(a) - int'(b) - int'(ci);
      sr   = int'($signed(a)) - int'($signed(b)) - int'(ci);
      e.co = (int'(a) < int'(b) + int'(ci));
    end
    e.d  = ur[7:0];
    e.ov = (sr < -128) || (sr > 127);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic mode);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.mode     = mode;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    check("drain_empty", 32'(sb.size()), 32'd0);
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        check("out_has_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_d",  32'(bus.d),  32'(e.d));
          check("sb_co", 32'(bus.co), 32'(e.co));
          check("sb_ov", 32'(bus.ov), 32'(e.ov));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.a, bus.b, bus.ci, bus.mode));
        accepted++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] hist;
    exp_t       x1;
    int         base;
    int         stale;

    // Reset with operands presented: nothing may be captured.
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    drive(8'h55, 8'h11, 1'b0, 1'b0);
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_d",         32'(bus.d),         32'd0);
    check("rst_co",        32'(bus.co),        32'd0);
    check("rst_ov",        32'(bus.ov),        32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    step();
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    step();
    step();
    step();
    check("no_capture_in_rst", 32'(bus.out_valid), 32'd0);
    check("no_accept_in_rst",  32'(accepted),      32'd0);

    // Latency and first vector with fixed expectations.
    $display("[TB] latency / basic subtract");
    drive(8'h06, 8'h09, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    check("v1_d",  32'(bus.d),  32'h0FC);
    check("v1_co", 32'(bus.co), 32'd1);
    check("v1_ov", 32'(bus.ov), 32'd0);
    step();

    $display("[TB] overflow and carry vectors");
    drive(8'h80, 8'h01, 1'b0, 1'b0); step();
    drive(8'h08, 8'h04, 1'b1, 1'b0); step();
    drive(8'hFF, 8'h01, 1'b0, 1'b1); step();
    drive(8'h7F, 8'h01, 1'b0, 1'b1); step();
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back: out_valid must be high for exactly four consecutive cycles.
    $display("[TB] back-to-back throughput");
    hist = '0;
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], vc[i], vm[i]);
      step();
      hist[i] = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    for (int i = 4; i < 6; i++) begin
      step();
      hist[i] = bus.out_valid;
    end
    check("b2b_valid_pattern", 32'(hist), 32'b011110);
    drain();

    // Backpressure: two items fill the pipe, then in_ready drops and d holds.
    $display("[TB] backpressure");
    base          = accepted;
    bus.out_ready = 1'b0;
    drive(8'h21, 8'h13, 1'b0, 1'b0);
    x1 = model(8'h21, 8'h13, 1'b0, 1'b0);
    step();
    drive(8'h44, 8'h22, 1'b1, 1'b1);
    step();
    drive(8'h77, 8'h66, 1'b0, 1'b0);
    check("bp_in_ready0", 32'(bus.in_ready), 32'd0);
    check("bp_d_hold0",   32'(bus.d),        32'(x1.d));
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_d_hold",    32'(bus.d),         32'(x1.d));
      check("bp_co_hold",   32'(bus.co),        32'(x1.co));
    end
    check("bp_accepted_two", 32'(accepted - base), 32'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);

    // Mid-flight reset discards both items and clears outputs immediately.
    $display("[TB] mid-flight reset");
    drive(8'h33, 8'h11, 1'b0, 1'b0); step();
    drive(8'h99, 8'h22, 1'b1, 1'b1); step();
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_d",         32'(bus.d),         32'd0);
    check("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    sb.delete();
    step();
    rst   = 1'b0;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid) stale++;
    end
    check("mrst_no_stale", 32'(stale), 32'd0);
    drive(8'h10, 8'h01, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("mrst_lat1", 32'(bus.out_valid), 32'd0);
    step();
    check("mrst_lat2", 32'(bus.out_valid), 32'd1);
    check("mrst_d_chunk_borrow", 32'(bus.d), 32'h00F);
    drain();

    // Random traffic with random backpressure; ordering is checked by the monitor.
    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      else
        bus.in_valid = 1'b0;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check("final_idle", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
